// File: rtl/snake_body.sv
// snake_body: owns the snake's body and streams its segments to the renderer.
//
// The body is a ring buffer of 2-bit link directions (each entry points from a
// segment toward the next, tail-side segment) plus a registered head position.
// Between game ticks the block walks head->tail one segment per clock, forever.
// A tick computes the next head cell, walks segments 0..len-2 looking for a
// self hit (CHECK), then moves/grows the snake or latches failure (COMMIT).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   game_rst_n          synchronous active-low game restart (same effect as rst_n)
//   tick                one-cycle move strobe (honoured only while streaming)
//   dir_in[1:0]         requested heading: 0=+y 1=-y 2=+x 3=-x
//   eat                 sampled in COMMIT; grow by one segment
//   snake_head_x/y      current head position
//   snake_x/y/dir       streamed segment position and link direction
//   snake_first/last    streamed segment is head / tail
//   snake_valid         stream outputs valid
//   failure, success    sticky end-of-game flags
//   busy                high while a move is being checked/committed
module snake_body #(
    parameter int GAME_WIDTH  = 18,
    parameter int GAME_HEIGHT = 13,
    parameter int MAX_LEN     = 64,
    parameter int INIT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_rst_n,
    input  logic       tick,
    input  logic [1:0] dir_in,
    input  logic       eat,
    output logic [4:0] snake_head_x,
    output logic [3:0] snake_head_y,
    output logic [4:0] snake_x,
    output logic [3:0] snake_y,
    output logic [1:0] snake_dir,
    output logic       snake_first,
    output logic       snake_last,
    output logic       snake_valid,
    output logic       failure,
    output logic       success,
    output logic       busy
);

    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = PW + 1;

    localparam logic [4:0]    GW    = 5'(GAME_WIDTH);
    localparam logic [3:0]    GH    = 4'(GAME_HEIGHT);
    localparam logic [LW-1:0] MAXL  = LW'(MAX_LEN);
    localparam logic [LW-1:0] INITL = LW'(INIT_LEN);

    typedef enum logic [1:0] {
        ST_STREAM,
        ST_CHECK,
        ST_COMMIT,
        ST_DEAD
    } state_t;

    state_t         state;
    logic [1:0]     mem [MAX_LEN];
    logic [PW-1:0]  head_ptr;
    logic [LW-1:0]  len;
    logic [1:0]     heading;

    // Walk cursor: ring pointer, segment index and that segment's position.
    logic [PW-1:0]  walk_ptr;
    logic [LW-1:0]  walk_cnt;
    logic [4:0]     walk_x;
    logic [3:0]     walk_y;

    // Candidate head for the move in progress and its collision flag.
    logic [4:0]     nh_x;
    logic [3:0]     nh_y;
    logic           hit;

    function automatic logic [4:0] step_x(input logic [4:0] x, input logic [1:0] d);
        case (d)
            2'd2:    step_x = x + 5'd1;
            2'd3:    step_x = x - 5'd1;
            default: step_x = x;
        endcase
    endfunction

    function automatic logic [3:0] step_y(input logic [3:0] y, input logic [1:0] d);
        case (d)
            2'd0:    step_y = y + 4'd1;
            2'd1:    step_y = y - 4'd1;
            default: step_y = y;
        endcase
    endfunction

    logic [1:0]    new_heading;
    logic [1:0]    cur_dir;
    logic [4:0]    step_hx, step_wx;
    logic [3:0]    step_hy, step_wy;
    logic          wall;
    logic          walk_last;
    logic          walk_match;
    logic          tail_hit;
    logic          grow;
    logic [LW-1:0] len_m1, len_m2, len_next;
    logic [PW-1:0] hp_m1;

    always_comb begin
        // A request to reverse onto the neck is dropped; keep going straight.
        new_heading = (dir_in == (heading ^ 2'b01)) ? heading : dir_in;
        step_hx     = step_x(snake_head_x, new_heading);
        step_hy     = step_y(snake_head_y, new_heading);
        wall        = (step_hx == 5'd0) || (step_hx > GW) ||
                      (step_hy == 4'd0) || (step_hy > GH);
        cur_dir     = mem[walk_ptr];
        step_wx     = step_x(walk_x, cur_dir);
        step_wy     = step_y(walk_y, cur_dir);
        len_m1      = len - LW'(1);
        len_m2      = len - LW'(2);
        walk_last   = (walk_cnt == len_m1);
        walk_match  = (walk_x == nh_x) && (walk_y == nh_y);
        // CHECK leaves the cursor on the tail; when growing the tail stays put,
        // so landing on it is a hit after all.
        tail_hit    = eat && walk_match;
        grow        = eat && (len != MAXL);
        len_next    = grow ? len + LW'(1) : len;
        hp_m1       = head_ptr - PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_STREAM;
            snake_head_x <= 5'd4;
            snake_head_y <= 4'd7;
            heading      <= 2'd2;
            len          <= INITL;
            head_ptr     <= '0;
            for (int i = 0; i < MAX_LEN; i++) mem[i] <= 2'd3;
            walk_ptr     <= '0;
            walk_cnt     <= '0;
            walk_x       <= 5'd4;
            walk_y       <= 4'd7;
            nh_x         <= '0;
            nh_y         <= '0;
            hit          <= 1'b0;
            failure      <= 1'b0;
            success      <= 1'b0;
            busy         <= 1'b0;
            snake_valid  <= 1'b0;
            snake_x      <= '0;
            snake_y      <= '0;
            snake_dir    <= '0;
            snake_first  <= 1'b0;
            snake_last   <= 1'b0;
        end else if (!game_rst_n) begin
            state        <= ST_STREAM;
            snake_head_x <= 5'd4;
            snake_head_y <= 4'd7;
            heading      <= 2'd2;
            len          <= INITL;
            head_ptr     <= '0;
            for (int i = 0; i < MAX_LEN; i++) mem[i] <= 2'd3;
            walk_ptr     <= '0;
            walk_cnt     <= '0;
            walk_x       <= 5'd4;
            walk_y       <= 4'd7;
            nh_x         <= '0;
            nh_y         <= '0;
            hit          <= 1'b0;
            failure      <= 1'b0;
            success      <= 1'b0;
            busy         <= 1'b0;
            snake_valid  <= 1'b0;
            snake_x      <= '0;
            snake_y      <= '0;
            snake_dir    <= '0;
            snake_first  <= 1'b0;
            snake_last   <= 1'b0;
        end else begin
            case (state)
                ST_STREAM, ST_DEAD: begin
                    if (state == ST_STREAM && tick) begin
                        heading     <= new_heading;
                        nh_x        <= step_hx;
                        nh_y        <= step_hy;
                        hit         <= wall;
                        busy        <= 1'b1;
                        snake_valid <= 1'b0;
                        walk_ptr    <= head_ptr;
                        walk_cnt    <= '0;
                        walk_x      <= snake_head_x;
                        walk_y      <= snake_head_y;
                        state       <= ST_CHECK;
                    end else begin
                        snake_x     <= walk_x;
                        snake_y     <= walk_y;
                        snake_dir   <= cur_dir;
                        snake_first <= (walk_cnt == '0);
                        snake_last  <= walk_last;
                        snake_valid <= 1'b1;
                        if (walk_last) begin
                            walk_ptr <= head_ptr;
                            walk_cnt <= '0;
                            walk_x   <= snake_head_x;
                            walk_y   <= snake_head_y;
                        end else begin
                            walk_ptr <= walk_ptr + PW'(1);
                            walk_cnt <= walk_cnt + LW'(1);
                            walk_x   <= step_wx;
                            walk_y   <= step_wy;
                        end
                    end
                end
                ST_CHECK: begin
                    if (walk_match) hit <= 1'b1;
                    walk_ptr <= walk_ptr + PW'(1);
                    walk_cnt <= walk_cnt + LW'(1);
                    walk_x   <= step_wx;
                    walk_y   <= step_wy;
                    // Once a hit is known the rest of the walk cannot change it.
                    if (hit || walk_match || walk_cnt == len_m2) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    busy     <= 1'b0;
                    walk_cnt <= '0;
                    if (hit || tail_hit) begin
                        failure  <= 1'b1;
                        state    <= ST_DEAD;
                        walk_ptr <= head_ptr;
                        walk_x   <= snake_head_x;
                        walk_y   <= snake_head_y;
                    end else begin
                        snake_head_x <= nh_x;
                        snake_head_y <= nh_y;
                        head_ptr     <= hp_m1;
                        mem[hp_m1]   <= heading ^ 2'b01;
                        len          <= len_next;
                        walk_ptr     <= hp_m1;
                        walk_x       <= nh_x;
                        walk_y       <= nh_y;
                        if (len_next == MAXL) begin
                            success <= 1'b1;
                            state   <= ST_DEAD;
                        end else begin
                            state <= ST_STREAM;
                        end
                    end
                end
                default: state <= ST_STREAM;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: reset stream, a table of moves with
// hand-computed head/length/flags, and hand sequences for tail vacating,
// wall hit, game restart mid-check and the winning length.
module tb_snake_body;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_rst_n = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] dir_in = 2'd0;
    logic       eat = 1'b0;
    logic [4:0] snake_head_x, snake_x;
    logic [3:0] snake_head_y, snake_y;
    logic [1:0] snake_dir;
    logic       snake_first, snake_last, snake_valid;
    logic       failure, success, busy;

    snake_body dut (
        .clk(clk), .rst_n(rst_n), .game_rst_n(game_rst_n), .tick(tick),
        .dir_in(dir_in), .eat(eat),
        .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
        .snake_x(snake_x), .snake_y(snake_y), .snake_dir(snake_dir),
        .snake_first(snake_first), .snake_last(snake_last),
        .snake_valid(snake_valid), .failure(failure), .success(success),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int last_busy;
    int busy_valid;
    int wn;
    int wx [80];
    int wy [80];
    int wd [80];

    typedef struct {
        logic [1:0] d;
        logic       e;
        int         ex;
        int         ey;
        int         elen;
        int         efail;
        int         esucc;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; game_rst_n = 1'b1; tick = 1'b0; eat = 1'b0; dir_in = 2'd0;
        @(negedge clk);
        check("rst_valid", int'(snake_valid), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
    endtask

    // Issue one tick and wait (bounded) for the move to finish.
    task automatic do_tick(input logic [1:0] d, input logic e);
        @(negedge clk);
        dir_in = d; eat = e; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        last_busy = 0;
        busy_valid = 0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            last_busy++;
            if (snake_valid) busy_valid++;
            @(negedge clk);
        end
        if (busy) check("busy_timeout", 1, 0);
        @(negedge clk);
    endtask

    // Record one full head-to-tail walk of the stream.
    task automatic capture_walk();
        bit found;
        wn = 0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            if (snake_valid && snake_first) begin found = 1; break; end
            @(negedge clk);
        end
        if (!found) begin
            check("walk_start", 0, 1);
            return;
        end
        for (int i = 0; i < 70; i++) begin
            wx[wn] = int'(snake_x); wy[wn] = int'(snake_y); wd[wn] = int'(snake_dir);
            wn++;
            if (snake_last) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hx, hy;
        int sp [61];
        int k;

        // ---- reset state and stream ----
        do_reset();
        @(negedge clk);
        check("valid_after_release", int'(snake_valid), 1);
        check("first_after_release", int'(snake_first), 1);
        capture_walk();
        check("rst_walk_len", wn, 3);
        check("rst_s0_x", wx[0], 4); check("rst_s0_y", wy[0], 7); check("rst_s0_d", wd[0], 3);
        check("rst_s1_x", wx[1], 3); check("rst_s1_y", wy[1], 7); check("rst_s1_d", wd[1], 3);
        check("rst_s2_x", wx[2], 2); check("rst_s2_y", wy[2], 7);
        check("rst_head_x", int'(snake_head_x), 4);
        check("rst_head_y", int'(snake_head_y), 7);
        check("rst_failure", int'(failure), 0);
        check("rst_success", int'(success), 0);

        // ---- first move +y ----
        do_tick(2'd0, 1'b0);
        check("mv_busy_cycles", last_busy, 3);
        check("mv_valid_in_busy", busy_valid, 0);
        check("mv_head_x", int'(snake_head_x), 4);
        check("mv_head_y", int'(snake_head_y), 8);
        capture_walk();
        check("mv_walk_len", wn, 3);
        check("mv_s0_x", wx[0], 4); check("mv_s0_y", wy[0], 8); check("mv_s0_d", wd[0], 1);
        check("mv_s1_x", wx[1], 4); check("mv_s1_y", wy[1], 7); check("mv_s1_d", wd[1], 3);
        check("mv_s2_x", wx[2], 3); check("mv_s2_y", wy[2], 7);

        // ---- table of moves from reset ----
        vt[0] = '{2'd3, 1'b0, 5, 7, 3, 0, 0};  // reversal ignored
        vt[1] = '{2'd0, 1'b0, 5, 8, 3, 0, 0};
        vt[2] = '{2'd1, 1'b0, 5, 9, 3, 0, 0};  // reversal ignored
        vt[3] = '{2'd2, 1'b1, 6, 9, 4, 0, 0};
        vt[4] = '{2'd3, 1'b1, 7, 9, 5, 0, 0};  // reversal ignored, grows
        vt[5] = '{2'd1, 1'b0, 7, 8, 5, 0, 0};
        vt[6] = '{2'd3, 1'b0, 6, 8, 5, 0, 0};
        vt[7] = '{2'd0, 1'b0, 6, 8, 5, 1, 0};  // into segment 3
        vt[8] = '{2'd2, 1'b1, 6, 8, 5, 1, 0};  // ignored when dead
        do_reset();
        for (int i = 0; i < 9; i++) begin
            do_tick(vt[i].d, vt[i].e);
            check($sformatf("vec%0d_head_x", i), int'(snake_head_x), vt[i].ex);
            check($sformatf("vec%0d_head_y", i), int'(snake_head_y), vt[i].ey);
            check($sformatf("vec%0d_failure", i), int'(failure), vt[i].efail);
            check($sformatf("vec%0d_success", i), int'(success), vt[i].esucc);
            capture_walk();
            check($sformatf("vec%0d_len", i), wn, vt[i].elen);
        end
        check("dead_tick_busy", last_busy, 0);

        // ---- move into the vacating tail cell ----
        do_reset();
        do_tick(2'd2, 1'b1);
        do_tick(2'd0, 1'b0);
        do_tick(2'd3, 1'b0);
        do_tick(2'd1, 1'b0);
        check("vacate_busy_cycles", last_busy, 4);
        check("vacate_failure", int'(failure), 0);
        check("vacate_head_x", int'(snake_head_x), 4);
        check("vacate_head_y", int'(snake_head_y), 7);

        // ---- same move while growing: tail stays, so it is a hit ----
        do_reset();
        do_tick(2'd2, 1'b1);
        do_tick(2'd0, 1'b0);
        do_tick(2'd3, 1'b0);
        do_tick(2'd1, 1'b1);
        check("growtail_failure", int'(failure), 1);
        check("growtail_head_x", int'(snake_head_x), 4);
        check("growtail_head_y", int'(snake_head_y), 8);
        capture_walk();
        check("growtail_len", wn, 4);

        // ---- wall on the right edge ----
        do_reset();
        for (int i = 0; i < 14; i++) do_tick(2'd2, 1'b0);
        check("edge_head_x", int'(snake_head_x), 18);
        check("edge_failure", int'(failure), 0);
        do_tick(2'd2, 1'b0);
        check("wall_busy_cycles", last_busy, 2);
        check("wall_failure", int'(failure), 1);
        check("wall_head_x", int'(snake_head_x), 18);
        check("wall_head_y", int'(snake_head_y), 7);
        capture_walk();
        check("wall_walk_len", wn, 3);
        check("wall_s0_x", wx[0], 18);
        check("wall_s2_x", wx[2], 16);

        // ---- game restart in the middle of CHECK ----
        do_reset();
        do_tick(2'd0, 1'b1);
        @(negedge clk);
        dir_in = 2'd2; eat = 1'b0; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("grst_busy_before", int'(busy), 1);
        game_rst_n = 1'b0;
        @(negedge clk);
        check("grst_busy", int'(busy), 0);
        check("grst_valid", int'(snake_valid), 0);
        check("grst_head_x", int'(snake_head_x), 4);
        check("grst_head_y", int'(snake_head_y), 7);
        check("grst_failure", int'(failure), 0);
        game_rst_n = 1'b1;
        @(negedge clk);
        check("grst_valid_after", int'(snake_valid), 1);
        capture_walk();
        check("grst_walk_len", wn, 3);
        check("grst_s2_x", wx[2], 2);

        // ---- serpentine to the winning length ----
        k = 0;
        for (int i = 0; i < 14; i++) sp[k++] = 2;
        sp[k++] = 0;
        for (int i = 0; i < 17; i++) sp[k++] = 3;
        sp[k++] = 0;
        for (int i = 0; i < 17; i++) sp[k++] = 2;
        sp[k++] = 0;
        for (int i = 0; i < 10; i++) sp[k++] = 3;
        do_reset();
        hx = 4; hy = 7;
        for (int i = 0; i < 61; i++) begin
            do_tick(2'(sp[i]), 1'b1);
            case (sp[i])
                0: hy++;
                1: hy--;
                2: hx++;
                default: hx--;
            endcase
            if (i == 59) check("win_success_early", int'(success), 0);
        end
        check("win_success", int'(success), 1);
        check("win_failure", int'(failure), 0);
        check("win_head_x", int'(snake_head_x), hx);
        check("win_head_y", int'(snake_head_y), hy);
        capture_walk();
        check("win_walk_len", wn, 64);
        do_tick(2'd1, 1'b1);
        check("win_tick_ignored", last_busy, 0);
        check("win_head_x_hold", int'(snake_head_x), hx);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Owns the snake's body state and produces the segment stream that the VGA renderer consumes.
- The body is stored as a ring buffer of 2-bit link directions plus a registered head position. On each game tick the block moves the snake, grows it when `eat` is set, and checks for wall and self collisions.
- Between ticks it walks the body from head to tail, one segment per clock, and repeats the walk continuously.
- It sits between the game controller (tick, direction, eat) and the renderer (head, segment stream, failure, success).

Parameters:
- GAME_WIDTH, 18: playfield columns. Legal x is 1..GAME_WIDTH; 0 and GAME_WIDTH+1 are wall.
- GAME_HEIGHT, 13: playfield rows. Legal y is 1..GAME_HEIGHT; 0 and GAME_HEIGHT+1 are wall.
- MAX_LEN, 64: ring buffer depth and winning length. Must be a power of two.
- INIT_LEN, 3: length after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- game_rst_n  in  1  synchronous active-low game restart; same effect as rst_n
- tick  in  1  one-cycle move strobe
- dir_in  in  2  requested heading: 0=+y, 1=-y, 2=+x, 3=-x
- eat  in  1  sampled in COMMIT; 1 = grow by one
- snake_head_x  out  5  head column
- snake_head_y  out  4  head row
- snake_x  out  5  streamed segment column
- snake_y  out  4  streamed segment row
- snake_dir  out  2  link direction from this segment toward the next (tail-side) segment
- snake_first  out  1  streamed segment is the head
- snake_last  out  1  streamed segment is the tail
- snake_valid  out  1  stream outputs are valid this cycle
- failure  out  1  sticky; wall or self hit
- success  out  1  sticky; length reached MAX_LEN
- busy  out  1  high in CHECK and COMMIT

Behaviour:
- Direction encoding: the opposite direction is d with bit0 inverted. Stepping +x/-x changes x by ±1; stepping +y/-y changes y by ±1. Arithmetic is at port widths with no saturation.
- Storage: mem[MAX_LEN] of 2 bits, head_ptr, len (log2(MAX_LEN)+1 bits), heading register.
- Segment k sits at mem[(head_ptr+k) mod MAX_LEN]. The position of segment k+1 is segment k's position stepped by its mem entry. The tail entry's value is don't-care.
- Reset (rst_n low, or game_rst_n low at a clock edge):
  - head=(4,7), heading=2, len=INIT_LEN, head_ptr=0, mem[0..INIT_LEN-1]=3.
  - State=STREAM with walk restarted; failure=0, success=0, busy=0, snake_valid=0.
- STREAM state:
  - Walk pointer p and count c start at head_ptr and 0. Each cycle a registered output emits (pos, mem[p], first=(c==0), last=(c==len-1), valid=1).
  - After the last segment, the next cycle restarts at the head. There are no bubbles; valid rises 1 cycle after reset release.
- Tick in STREAM (while not failure/success):
  - Latch new heading: dir_in, unless dir_in is opposite the current heading, in which case keep the heading.
  - Compute nh = head stepped by the new heading. Go to CHECK with snake_valid=0.
- CHECK state:
  - If nh is on a wall, set hit immediately.
  - Otherwise walk segments 0..len-2 (the tail is excluded, because it vacates the cell). Each visited segment equal to nh sets hit. Takes len-1 cycles. Ticks are ignored.
- COMMIT state (1 cycle), sampling eat:
  - If hit: failure<=1, state DEAD, head and body unchanged.
  - Else:
    - head<=nh, head_ptr<=head_ptr-1 (mod MAX_LEN), mem[head_ptr-1]<=opposite(heading).
    - If eat and len<MAX_LEN: len<=len+1.
    - If the resulting len==MAX_LEN: success<=1, state DEAD.
    - Restart the walk and return to STREAM.
- DEAD state: keep streaming the frozen body (valid toggles as in STREAM); ticks are ignored. Exit only via reset or game_rst_n.
- eat in the same tick as a collision has no effect.
- Growing into the old tail cell counts as a hit, since the tail does not move. This is a known limitation: the tail was excluded from CHECK, so this case is resolved in COMMIT by re-checking nh against the tail position when eat=1.
- busy=1 from the cycle after the accepted tick through COMMIT.

Test Plan:
- Release reset, hold tick=0 -> stream repeats (4,7,d3,first), (3,7,d3), (2,7,last); head=(4,7); failure=success=0.
- tick with dir_in=0, eat=0 -> after CHECK+COMMIT, head=(4,8); stream (4,8,d1,first), (4,7,d3), (3,7,last); len stays 3.
- tick with dir_in=3 from reset heading +x -> reversal ignored; head=(5,7).
- Repeated ticks with eat=1 -> len increments each time; tail unchanged on the first grow; success rises when len=MAX_LEN and later ticks are ignored.
- Steer the head to x=GAME_WIDTH, then tick +x -> failure=1, head stays at (18,y), stream continues frozen.
- Build len 5, then turn +y, -x, -y into the body -> failure=1. Moving into the vacating tail cell with eat=0 -> no failure.
- Assert game_rst_n mid-CHECK -> all state returns to reset values on the next edge; busy=0.
